// File: rtl/test_sequencer.sv
// Run controller: resets the driver, waits for its latency calibration,
// enables stimulus, counts compared vectors/mismatches and latches a verdict.
module test_sequencer #(
    parameter int DELAY_W     = 4,
    parameter int CNT_W       = 32,
    parameter int NUM_VECTORS = 1000,
    parameter int CAL_TIMEOUT = 4096,
    parameter int RST_CYCLES  = 2
) (
    input  logic               clk_dut,
    input  logic               reset_n,
    input  logic               i_start,
    input  logic               i_abort,
    input  logic [DELAY_W-1:0] i_dut_delay,
    input  logic               i_cmp_valid,
    input  logic               i_mismatch,
    output logic               o_drv_reset,
    output logic               o_lfsr_en,
    output logic               o_busy,
    output logic               o_done,
    output logic               o_pass,
    output logic               o_cal_err,
    output logic [DELAY_W-1:0] o_delay,
    output logic [CNT_W-1:0]   o_vec_count,
    output logic [CNT_W-1:0]   o_err_count
);

    localparam int TMO_W = $clog2(CAL_TIMEOUT) + 1;
    localparam int RST_W = $clog2(RST_CYCLES) + 1;

    typedef enum logic [4:0] {
        S_IDLE = 5'b00001,
        S_DRST = 5'b00010,
        S_CAL  = 5'b00100,
        S_RUN  = 5'b01000,
        S_DONE = 5'b10000
    } state_t;

    state_t             r_state;
    state_t             w_next;
    logic               r_start_q;
    logic [TMO_W-1:0]   r_tmo;
    logic [RST_W-1:0]   r_rst_cnt;
    logic [DELAY_W-1:0] r_delay;
    logic [CNT_W-1:0]   r_vec;
    logic [CNT_W-1:0]   r_err;
    logic               r_cal_err;

    logic w_start_edge;
    logic w_delay_ok;
    logic w_tmo_hit;
    logic w_rst_last;
    logic w_last_vec;

    assign w_start_edge = i_start & ~r_start_q;
    assign w_delay_ok   = (i_dut_delay != '1);
    assign w_tmo_hit    = (r_tmo == TMO_W'(CAL_TIMEOUT - 1));
    assign w_rst_last   = (r_rst_cnt == RST_W'(RST_CYCLES - 1));
    assign w_last_vec   = (r_vec == CNT_W'(NUM_VECTORS - 1));

    always_ff @(posedge clk_dut or negedge reset_n) begin
        if (!reset_n) r_state <= S_IDLE;
        else          r_state <= w_next;
    end

    // Abort overrides every transition, start edge included.
    always_comb begin
        w_next = r_state;
        if (i_abort) begin
            w_next = S_IDLE;
        end else begin
            unique case (r_state)
                S_IDLE: if (w_start_edge) w_next = S_DRST;
                S_DRST: if (w_rst_last) w_next = S_CAL;
                S_CAL: begin
                    if (w_delay_ok)     w_next = S_RUN;
                    else if (w_tmo_hit) w_next = S_DONE;
                end
                S_RUN:  if (i_cmp_valid && w_last_vec) w_next = S_DONE;
                S_DONE: if (w_start_edge) w_next = S_DRST;
                default: w_next = S_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk_dut or negedge reset_n) begin
        if (!reset_n) begin
            r_start_q <= 1'b0;
            r_tmo     <= '0;
            r_rst_cnt <= '0;
            r_delay   <= '1;
            r_vec     <= '0;
            r_err     <= '0;
            r_cal_err <= 1'b0;
        end else begin
            r_start_q <= i_start;
            if (!i_abort) begin
                unique case (r_state)
                    S_IDLE, S_DONE: begin
                        if (w_start_edge) begin
                            r_tmo     <= '0;
                            r_rst_cnt <= '0;
                            r_delay   <= '1;
                            r_vec     <= '0;
                            r_err     <= '0;
                            r_cal_err <= 1'b0;
                        end
                    end
                    S_DRST: r_rst_cnt <= r_rst_cnt + 1'b1;
                    S_CAL: begin
                        r_tmo <= r_tmo + 1'b1;
                        if (w_delay_ok)     r_delay   <= i_dut_delay;
                        else if (w_tmo_hit) r_cal_err <= 1'b1;
                    end
                    S_RUN: begin
                        if (i_cmp_valid) begin
                            r_vec <= r_vec + 1'b1;
                            if (i_mismatch && r_err != '1)
                                r_err <= r_err + 1'b1;
                        end
                    end
                    default: ;
                endcase
            end
        end
    end

    assign o_drv_reset = (r_state == S_IDLE) | (r_state == S_DRST);
    assign o_lfsr_en   = (r_state == S_CAL) | (r_state == S_RUN);
    assign o_busy      = (r_state == S_DRST) | o_lfsr_en;
    assign o_done      = (r_state == S_DONE);
    assign o_pass      = o_done & (r_err == '0) & ~r_cal_err;
    assign o_cal_err   = r_cal_err;
    assign o_delay     = r_delay;
    assign o_vec_count = r_vec;
    assign o_err_count = r_err;

endmodule

// File: tb/tb_test_sequencer.sv
// Directed bench for test_sequencer: normal run, mismatches, calibration
// timeout, abort, re-run and asynchronous reset.
module tb_test_sequencer;

    logic        clk_dut;
    logic        reset_n;
    logic        i_start;
    logic        i_abort;
    logic [3:0]  i_dut_delay;
    logic        i_cmp_valid;
    logic        i_mismatch;
    logic        o_drv_reset;
    logic        o_lfsr_en;
    logic        o_busy;
    logic        o_done;
    logic        o_pass;
    logic        o_cal_err;
    logic [3:0]  o_delay;
    logic [31:0] o_vec_count;
    logic [31:0] o_err_count;

    int checks = 0;
    int passes = 0;

    test_sequencer #(
        .DELAY_W(4), .CNT_W(32), .NUM_VECTORS(8),
        .CAL_TIMEOUT(16), .RST_CYCLES(2)
    ) dut (
        .clk_dut(clk_dut), .reset_n(reset_n),
        .i_start(i_start), .i_abort(i_abort),
        .i_dut_delay(i_dut_delay), .i_cmp_valid(i_cmp_valid),
        .i_mismatch(i_mismatch), .o_drv_reset(o_drv_reset),
        .o_lfsr_en(o_lfsr_en), .o_busy(o_busy), .o_done(o_done),
        .o_pass(o_pass), .o_cal_err(o_cal_err), .o_delay(o_delay),
        .o_vec_count(o_vec_count), .o_err_count(o_err_count)
    );

    initial begin
        clk_dut = 1'b0;
        forever #5 clk_dut = ~clk_dut;
    end

    // {drv_reset, lfsr_en, busy, done, pass, cal_err}
    function automatic logic [5:0] flags();
        return {o_drv_reset, o_lfsr_en, o_busy, o_done, o_pass, o_cal_err};
    endfunction

    task automatic tick();
        @(posedge clk_dut);
        #1;
    endtask

    task automatic start_pulse();
        i_start = 1'b1;
        tick();
        i_start = 1'b0;
    endtask

    task automatic send_vecs(input int n, input logic [7:0] mask);
        for (int i = 0; i < n; i++) begin
            i_cmp_valid = 1'b1;
            i_mismatch  = mask[i];
            tick();
        end
        i_cmp_valid = 1'b0;
        i_mismatch  = 1'b0;
    endtask

    // start -> DRST(2) -> CAL(5 cycles, delay 3) -> RUN
    task automatic go_to_run(input logic [3:0] dly);
        i_dut_delay = 4'hF;
        start_pulse();
        tick();
        tick();
        repeat (4) tick();
        i_dut_delay = dly;
        tick();
    endtask

    task automatic test_reset();
        reset_n = 1'b0;
        repeat (2) tick();
        checks++;
        if (flags() !== 6'b100000)
            $display("FAIL reset_flags got=%b exp=100000", flags());
        else passes++;
        checks++;
        if ({o_delay, o_vec_count, o_err_count} !== {4'hF, 64'd0})
            $display("FAIL reset_vals got=%h/%0d/%0d exp=f/0/0",
                     o_delay, o_vec_count, o_err_count);
        else passes++;
        reset_n = 1'b1;
        tick();
    endtask

    task automatic test_normal();
        i_dut_delay = 4'hF;
        start_pulse();
        checks++;
        if (flags() !== 6'b101000)
            $display("FAIL drst_flags got=%b exp=101000", flags());
        else passes++;
        tick();
        tick();
        checks++;
        if ({flags(), o_delay} !== {6'b011000, 4'hF})
            $display("FAIL cal_flags got=%b/%h exp=011000/f", flags(), o_delay);
        else passes++;
        repeat (4) tick();
        i_dut_delay = 4'd3;
        tick();
        checks++;
        if ({flags(), o_delay} !== {6'b011000, 4'd3})
            $display("FAIL run_entry got=%b/%h exp=011000/3", flags(), o_delay);
        else passes++;
        send_vecs(7, 8'h00);
        checks++;
        if ({o_busy, o_vec_count} !== {1'b1, 32'd7})
            $display("FAIL run_7 got=%b/%0d exp=1/7", o_busy, o_vec_count);
        else passes++;
        send_vecs(1, 8'h00);
        checks++;
        if (flags() !== 6'b000110)
            $display("FAIL normal_done got=%b exp=000110", flags());
        else passes++;
        checks++;
        if ({o_vec_count, o_err_count, o_delay} !== {32'd8, 32'd0, 4'd3})
            $display("FAIL normal_cnt got=%0d/%0d/%h exp=8/0/3",
                     o_vec_count, o_err_count, o_delay);
        else passes++;
    endtask

    task automatic test_mismatch();
        go_to_run(4'd3);
        send_vecs(8, 8'b0100_0010);
        checks++;
        if ({flags(), o_err_count, o_vec_count} !== {6'b000100, 32'd2, 32'd8})
            $display("FAIL mism_done got=%b/%0d/%0d exp=000100/2/8",
                     flags(), o_err_count, o_vec_count);
        else passes++;
        send_vecs(3, 8'hFF);
        checks++;
        if ({o_done, o_err_count, o_vec_count} !== {1'b1, 32'd2, 32'd8})
            $display("FAIL after_done got=%b/%0d/%0d exp=1/2/8",
                     o_done, o_err_count, o_vec_count);
        else passes++;
    endtask

    task automatic test_cal_timeout();
        i_dut_delay = 4'hF;
        start_pulse();
        tick();
        tick();
        repeat (15) tick();
        checks++;
        if ({o_lfsr_en, o_done, o_cal_err} !== 3'b100)
            $display("FAIL cal_15 got=%b exp=100", {o_lfsr_en, o_done, o_cal_err});
        else passes++;
        tick();
        checks++;
        if (flags() !== 6'b000101)
            $display("FAIL tmo_done got=%b exp=000101", flags());
        else passes++;
        checks++;
        if ({o_vec_count, o_err_count, o_delay} !== {64'd0, 4'hF})
            $display("FAIL tmo_cnt got=%0d/%0d/%h exp=0/0/f",
                     o_vec_count, o_err_count, o_delay);
        else passes++;
    endtask

    task automatic test_abort();
        i_dut_delay = 4'hF;
        i_start = 1'b1;
        tick();
        tick();
        tick();
        i_dut_delay = 4'd3;
        tick();
        checks++;
        if ({o_lfsr_en, o_cal_err} !== 2'b10)
            $display("FAIL abort_run got=%b exp=10", {o_lfsr_en, o_cal_err});
        else passes++;
        send_vecs(3, 8'h00);
        i_abort = 1'b1;
        tick();
        i_abort = 1'b0;
        checks++;
        if ({flags(), o_vec_count} !== {6'b100000, 32'd3})
            $display("FAIL abort_idle got=%b/%0d exp=100000/3",
                     flags(), o_vec_count);
        else passes++;
        repeat (3) tick();
        checks++;
        if (o_busy !== 1'b0)
            $display("FAIL held_start got=%b exp=0", o_busy);
        else passes++;
        i_start = 1'b0;
        tick();
        i_start = 1'b1;
        i_abort = 1'b1;
        tick();
        i_abort = 1'b0;
        tick();
        checks++;
        if ({o_busy, o_vec_count} !== {1'b0, 32'd3})
            $display("FAIL abort_prio got=%b/%0d exp=0/3", o_busy, o_vec_count);
        else passes++;
        i_start = 1'b0;
        tick();
    endtask

    task automatic test_back_to_back();
        go_to_run(4'd3);
        send_vecs(8, 8'h01);
        checks++;
        if ({flags(), o_err_count} !== {6'b000100, 32'd1})
            $display("FAIL pre_rerun got=%b/%0d exp=000100/1",
                     flags(), o_err_count);
        else passes++;
        i_dut_delay = 4'hF;
        start_pulse();
        checks++;
        if ({o_drv_reset, o_vec_count, o_err_count, o_delay} !==
            {1'b1, 64'd0, 4'hF})
            $display("FAIL rerun_clr got=%b/%0d/%0d/%h exp=1/0/0/f",
                     o_drv_reset, o_vec_count, o_err_count, o_delay);
        else passes++;
        tick();
        checks++;
        if (o_drv_reset !== 1'b1)
            $display("FAIL rerun_rst2 got=%b exp=1", o_drv_reset);
        else passes++;
        tick();
        checks++;
        if ({o_drv_reset, o_lfsr_en, o_delay} !== {2'b01, 4'hF})
            $display("FAIL rerun_cal got=%b/%h exp=01/f",
                     {o_drv_reset, o_lfsr_en}, o_delay);
        else passes++;
        tick();
        i_dut_delay = 4'd5;
        tick();
        checks++;
        if ({o_lfsr_en, o_delay} !== {1'b1, 4'd5})
            $display("FAIL rerun_dly got=%b/%h exp=1/5", o_lfsr_en, o_delay);
        else passes++;
    endtask

    task automatic test_async_reset();
        send_vecs(2, 8'h03);
        i_abort = 1'b1;
        tick();
        i_abort = 1'b0;
        i_dut_delay = 4'hF;
        start_pulse();
        tick();
        tick();
        #2;
        reset_n = 1'b0;
        #1;
        checks++;
        if ({flags(), o_delay} !== {6'b100000, 4'hF})
            $display("FAIL async_rst got=%b/%h exp=100000/f", flags(), o_delay);
        else passes++;
        tick();
        reset_n = 1'b1;
        tick();
        checks++;
        if ({o_busy, o_drv_reset} !== 2'b01)
            $display("FAIL post_rst got=%b exp=01", {o_busy, o_drv_reset});
        else passes++;
    endtask

    initial begin
        reset_n     = 1'b0;
        i_start     = 1'b0;
        i_abort     = 1'b0;
        i_dut_delay = 4'hF;
        i_cmp_valid = 1'b0;
        i_mismatch  = 1'b0;
        test_reset();
        test_normal();
        test_mismatch();
        test_cal_timeout();
        test_abort();
        test_back_to_back();
        test_async_reset();
        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
